// File: rtl/rpn_pkg.sv
// Shared opcodes, error codes and FSM encoding for the RPN stack engine.
package rpn_pkg;

    localparam logic [2:0] OP_PUSH  = 3'b000;
    localparam logic [2:0] OP_POP   = 3'b001;
    localparam logic [2:0] OP_ADD   = 3'b010;
    localparam logic [2:0] OP_SUB   = 3'b011;
    localparam logic [2:0] OP_MUL   = 3'b100;
    localparam logic [2:0] OP_DUP   = 3'b101;
    localparam logic [2:0] OP_SWAP  = 3'b110;
    localparam logic [2:0] OP_CLEAR = 3'b111;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_OVF  = 2'b01;
    localparam logic [1:0] ERR_UNF  = 2'b10;
    localparam logic [1:0] ERR_ILL  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_EXEC = 2'd2
    } state_t;

endpackage

// File: rtl/rpn_stack_ram.sv
// Stack storage below TOS: one write port, one registered read port, no reset.
module rpn_stack_ram #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              CLOCK_50,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge CLOCK_50) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/rpn_stack_engine.sv
// RPN calculator core: TOS register, stack RAM, ALU and command FSM.
// Define RPN_MUL_EN to enable opcode 100 (MUL); otherwise it is an illegal opcode.
module rpn_stack_engine
    import rpn_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 16,
    localparam int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              CLOCK_50,
    input  logic              RESET_N,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_data,
    output logic [DATA_W-1:0] top_value,
    output logic              top_valid,
    output logic [CNT_W-1:0]  count,
    output logic              err,
    output logic [1:0]        err_code
);

    localparam int AW = $clog2(DEPTH);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] tos_q, tos_d;
    logic [2:0]        op_q, op_d;
    logic              err_q, err_d;
    logic [1:0]        err_code_q, err_code_d;

    logic              ram_we;
    logic [AW-1:0]     ram_waddr;
    logic [DATA_W-1:0] ram_wdata;
    logic [AW-1:0]     ram_raddr;
    logic [DATA_W-1:0] ram_rdata;

    logic              is_empty, is_full, lt_two;

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == CNT_W'(DEPTH));
    assign lt_two   = (count_q < CNT_W'(2));

    rpn_stack_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .CLOCK_50 (CLOCK_50),
        .we       (ram_we),
        .waddr    (ram_waddr),
        .wdata    (ram_wdata),
        .raddr    (ram_raddr),
        .rdata    (ram_rdata)
    );

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            tos_q      <= '0;
            op_q       <= OP_PUSH;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            tos_q      <= tos_d;
            op_q       <= op_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        tos_d      = tos_q;
        op_d       = op_q;
        err_d      = err_q;
        err_code_d = err_code_q;
        ram_we     = 1'b0;
        ram_waddr  = AW'(count_q - CNT_W'(1));
        ram_wdata  = tos_q;
        // Second entry address; held at 0 below two entries so it never wraps.
        ram_raddr  = lt_two ? '0 : AW'(count_q - CNT_W'(2));

        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_op == OP_CLEAR) begin
                        count_d    = '0;
                        tos_d      = '0;
                        err_d      = 1'b0;
                        err_code_d = ERR_NONE;
                    end else if (!err_q) begin
                        case (cmd_op)
                            OP_PUSH: begin
                                if (is_full) begin
                                    err_d      = 1'b1;
                                    err_code_d = ERR_OVF;
                                end else begin
                                    ram_we  = !is_empty;
                                    tos_d   = cmd_data;
                                    count_d = count_q + CNT_W'(1);
                                end
                            end
                            OP_DUP: begin
                                if (is_empty) begin
                                    err_d      = 1'b1;
                                    err_code_d = ERR_UNF;
                                end else if (is_full) begin
                                    err_d      = 1'b1;
                                    err_code_d = ERR_OVF;
                                end else begin
                                    ram_we  = 1'b1;
                                    count_d = count_q + CNT_W'(1);
                                end
                            end
                            OP_POP: begin
                                if (is_empty) begin
                                    err_d      = 1'b1;
                                    err_code_d = ERR_UNF;
                                end else begin
                                    op_d    = cmd_op;
                                    state_d = S_READ;
                                end
                            end
`ifndef RPN_MUL_EN
                            OP_MUL: begin
                                err_d      = 1'b1;
                                err_code_d = ERR_ILL;
                            end
`endif
                            default: begin
                                if (lt_two) begin
                                    err_d      = 1'b1;
                                    err_code_d = ERR_UNF;
                                end else begin
                                    op_d    = cmd_op;
                                    state_d = S_READ;
                                end
                            end
                        endcase
                    end
                end
            end
            S_READ: begin
                state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_IDLE;
                case (op_q)
                    OP_POP: begin
                        tos_d   = (count_q == CNT_W'(1)) ? '0 : ram_rdata;
                        count_d = count_q - CNT_W'(1);
                    end
                    OP_ADD: begin
                        tos_d   = ram_rdata + tos_q;
                        count_d = count_q - CNT_W'(1);
                    end
                    OP_SUB: begin
                        tos_d   = ram_rdata - tos_q;
                        count_d = count_q - CNT_W'(1);
                    end
`ifdef RPN_MUL_EN
                    OP_MUL: begin
                        tos_d   = ram_rdata * tos_q;
                        count_d = count_q - CNT_W'(1);
                    end
`endif
                    OP_SWAP: begin
                        ram_we    = 1'b1;
                        ram_waddr = ram_raddr;
                        tos_d     = ram_rdata;
                    end
                    default: ;
                endcase
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign cmd_ready = (state_q == S_IDLE);
    assign top_valid = !is_empty;
    assign top_value = is_empty ? '0 : tos_q;
    assign count     = count_q;
    assign err       = err_q;
    assign err_code  = err_code_q;

endmodule

// File: tb/tb_rpn_stack_engine.sv
// Directed bench for rpn_stack_engine (DATA_W=8, DEPTH=4) with a queue-based reference model.
module tb_rpn_stack_engine;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    typedef struct {
        logic [7:0] top;
        int         cnt;
        logic       err;
        logic [1:0] code;
        int         busy;
    } exp_t;

    logic              CLOCK_50;
    logic              RESET_N;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_op;
    logic [DATA_W-1:0] cmd_data;
    logic [DATA_W-1:0] top_value;
    logic              top_valid;
    logic [CNT_W-1:0]  count;
    logic              err;
    logic [1:0]        err_code;

    int n_assert;
    int n_fail;

    logic [7:0] mstk[$];
    logic       merr;
    logic [1:0] mcode;
    exp_t       sb[$];

    rpn_stack_engine #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .CLOCK_50  (CLOCK_50),
        .RESET_N   (RESET_N),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .top_value (top_value),
        .top_valid (top_valid),
        .count     (count),
        .err       (err),
        .err_code  (err_code)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference: mstk[$] is TOS; predicts result and busy cycles of each command.
    function automatic void model(input logic [2:0] op, input logic [7:0] d);
        exp_t       e;
        int         n;
        logic [7:0] a, b, r;
        bit         multi;
        n = mstk.size();
        multi = 0;
        if (op == 3'b111) begin
            mstk.delete();
            merr  = 0;
            mcode = 2'b00;
        end else if (!merr) begin
            case (op)
                3'b000: if (n == DEPTH) begin merr = 1; mcode = 2'b01; end
                        else mstk.push_back(d);
                3'b101: if (n == 0) begin merr = 1; mcode = 2'b10; end
                        else if (n == DEPTH) begin merr = 1; mcode = 2'b01; end
                        else mstk.push_back(mstk[n-1]);
                3'b001: if (n == 0) begin merr = 1; mcode = 2'b10; end
                        else begin multi = 1; a = mstk.pop_back(); end
`ifndef RPN_MUL_EN
                3'b100: begin merr = 1; mcode = 2'b11; end
`endif
                default: begin
                    if (n < 2) begin
                        merr = 1; mcode = 2'b10;
                    end else begin
                        multi = 1;
                        a = mstk.pop_back();
                        b = mstk.pop_back();
                        case (op)
                            3'b010: r = b + a;
                            3'b011: r = b - a;
                            3'b100: r = b * a;
                            default: r = 8'h00;
                        endcase
                        if (op == 3'b110) begin
                            mstk.push_back(a);
                            mstk.push_back(b);
                        end else begin
                            mstk.push_back(r);
                        end
                    end
                end
            endcase
        end
        e.busy = multi ? 2 : 0;
        e.cnt  = mstk.size();
        e.top  = (mstk.size() != 0) ? mstk[mstk.size()-1] : 8'h00;
        e.err  = merr;
        e.code = mcode;
        sb.push_back(e);
    endfunction

    task automatic check_out(input string tag, input int busy);
        exp_t e;
        e = sb.pop_front();
        chk({tag, ".busy"}, 16'(busy), 16'(e.busy));
        chk({tag, ".top"}, 16'(top_value), 16'(e.top));
        chk({tag, ".cnt"}, 16'(count), 16'(e.cnt));
        chk({tag, ".tv"}, 16'(top_valid), 16'(e.cnt != 0));
        chk({tag, ".err"}, 16'(err), 16'(e.err));
        chk({tag, ".code"}, 16'(err_code), 16'(e.code));
    endtask

    task automatic send(input string tag, input logic [2:0] op, input logic [7:0] d);
        int busy;
        model(op, d);
        @(negedge CLOCK_50);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        @(posedge CLOCK_50);
        #1;
        cmd_valid = 1'b0;
        busy = 0;
        while (!cmd_ready && busy < 20) begin
            busy++;
            @(posedge CLOCK_50);
            #1;
        end
        check_out(tag, busy);
    endtask

    initial begin
        n_assert  = 0;
        n_fail    = 0;
        merr      = 0;
        mcode     = 2'b00;
        RESET_N   = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 3'b000;
        cmd_data  = '0;
        repeat (3) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        RESET_N = 1'b1;
        @(posedge CLOCK_50);
        #1;
        chk("rst.ready", 16'(cmd_ready), 16'd1);
        chk("rst.cnt", 16'(count), 16'd0);
        chk("rst.top", 16'(top_value), 16'd0);
        chk("rst.tv", 16'(top_valid), 16'd0);
        chk("rst.err", 16'(err), 16'd0);
        chk("rst.code", 16'(err_code), 16'd0);

        send("p5", 3'b000, 8'd5);
        send("p3", 3'b000, 8'd3);
        send("sub", 3'b011, 8'd0);
        chk("sub.top_const", 16'(top_value), 16'h02);
        send("clr", 3'b111, 8'd0);

        send("p3", 3'b000, 8'd3);
        send("p5", 3'b000, 8'd5);
        send("subw", 3'b011, 8'd0);
        chk("subw.top_const", 16'(top_value), 16'hFE);
        send("clr", 3'b111, 8'd0);
        send("p200", 3'b000, 8'd200);
        send("p100", 3'b000, 8'd100);
        send("addw", 3'b010, 8'd0);
        chk("addw.top_const", 16'(top_value), 16'h2C);
        send("clr", 3'b111, 8'd0);

        for (int i = 1; i <= 4; i++) send("fill", 3'b000, 8'(i));
        send("ovf", 3'b000, 8'd9);
        chk("ovf.code_const", 16'(err_code), 16'h1);
        send("drop_add", 3'b010, 8'd0);
        send("drop_push", 3'b000, 8'd1);
        send("clr", 3'b111, 8'd0);

        send("pop_empty", 3'b001, 8'd0);
        send("clr", 3'b111, 8'd0);
        send("p7", 3'b000, 8'd7);
        send("swap_unf", 3'b110, 8'd0);
        chk("swap_unf.top_const", 16'(top_value), 16'h07);
        send("clr", 3'b111, 8'd0);

        send("p6", 3'b000, 8'd6);
        send("p9", 3'b000, 8'd9);
        send("swap", 3'b110, 8'd0);
        chk("swap.top_const", 16'(top_value), 16'h06);
        send("pop1", 3'b001, 8'd0);
        send("pop2", 3'b001, 8'd0);
        chk("pop2.tv_const", 16'(top_valid), 16'd0);

        send("dup_empty", 3'b101, 8'd0);
        send("clr", 3'b111, 8'd0);
        send("p4", 3'b000, 8'd4);
        send("dup", 3'b101, 8'd0);
        send("add_dup", 3'b010, 8'd0);
        send("p1", 3'b000, 8'd1);
        send("p2", 3'b000, 8'd2);
        send("dup_fill", 3'b101, 8'd0);
        send("dup_ovf", 3'b101, 8'd0);
        send("clr", 3'b111, 8'd0);

        send("p12", 3'b000, 8'h12);
        send("p10", 3'b000, 8'h10);
        send("mul", 3'b100, 8'd0);
`ifdef RPN_MUL_EN
        chk("mul.top_const", 16'(top_value), 16'h20);
`else
        chk("mul.code_const", 16'(err_code), 16'h3);
`endif
        send("clr", 3'b111, 8'd0);

        // Reset asserted during the READ cycle of an ADD.
        send("p1", 3'b000, 8'd1);
        send("p2", 3'b000, 8'd2);
        @(negedge CLOCK_50);
        cmd_valid = 1'b1;
        cmd_op    = 3'b010;
        @(posedge CLOCK_50);
        #1;
        cmd_valid = 1'b0;
        chk("rstop.in_read", 16'(cmd_ready), 16'd0);
        #2;
        RESET_N = 1'b0;
        #1;
        chk("rstop.async_cnt", 16'(count), 16'd0);
        @(negedge CLOCK_50);
        RESET_N = 1'b1;
        mstk.delete();
        merr  = 0;
        mcode = 2'b00;
        @(posedge CLOCK_50);
        #1;
        chk("rstop.ready", 16'(cmd_ready), 16'd1);
        chk("rstop.cnt", 16'(count), 16'd0);
        chk("rstop.err", 16'(err), 16'd0);
        chk("rstop.top", 16'(top_value), 16'd0);
        send("post_rst", 3'b000, 8'h55);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
